// File: rtl/calc_pkg.sv
// Shared opcodes, FSM state encoding and constants for the switch-driven calculator.
package calc_pkg;

  localparam int CALC_W = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Wide all-ones pattern; users slice off the 2*W bits they need.
  localparam logic [63:0] DIV0_RESULT = '1;

endpackage

// File: rtl/calc_sequencer_if.sv
// Request/result bundle between the board front end and calc_sequencer.
// acc_sel exists only when CALC_ACCUM_EN is defined.
interface calc_sequencer_if #(parameter int W = calc_pkg::CALC_W);

  logic           start;
  logic [1:0]     op;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] result;
  logic           err;
`ifdef CALC_ACCUM_EN
  logic           acc_sel;
`endif

  modport master (
`ifdef CALC_ACCUM_EN
    output acc_sel,
`endif
    output start, op, a, b,
    input  busy, done, result, err
  );

  modport slave (
`ifdef CALC_ACCUM_EN
    input  acc_sel,
`endif
    input  start, op, a, b,
    output busy, done, result, err
  );

endinterface

// File: rtl/calc_div_iter.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, W cycles after load.
module calc_div_iter import calc_pkg::*; #(
  parameter int W = CALC_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         valid
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          run_q, run_d;
  logic [W-1:0]  quo_q, quo_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  dsr_q, dsr_d;
  logic [W:0]    rem_shift;
  logic          take;

  always_comb begin
    cnt_d     = cnt_q;
    run_d     = run_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    rem_shift = {rem_q, quo_q[W-1]};
    take      = (rem_shift >= {1'b0, dsr_q});
    if (load) begin
      quo_d = dividend;
      rem_d = '0;
      dsr_d = divisor;
      cnt_d = CW'(W);
      run_d = 1'b1;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        // Partial remainder stays below the divisor, so W bits always suffice.
        rem_d = take ? W'(rem_shift - {1'b0, dsr_q}) : rem_shift[W-1:0];
        quo_d = {quo_q[W-2:0], take};
        cnt_d = cnt_q - CW'(1);
      end else begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      run_q <= 1'b0;
      quo_q <= '0;
      rem_q <= '0;
      dsr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      run_q <= run_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dsr_q <= dsr_d;
    end
  end

  assign valid     = run_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/calc_sequencer.sv
// Multi-cycle calculator controller: capture, execute or divide, then a held result with a done pulse.
// Optional chained-operand mode is enabled by defining CALC_ACCUM_EN.
//
//   state   | meaning
//   IDLE    | waiting for start; captures operands and opcode
//   EXEC    | single-cycle add/sub/mul
//   DIV     | iterative divider running
//   DONE    | result/err just registered, done pulse
module calc_sequencer import calc_pkg::*; #(
  parameter int W = CALC_W
) (
  input  logic               clk,
  input  logic               rst,
  calc_sequencer_if.slave    bus
);

  state_t         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [1:0]     op_q, op_d;
  logic [2*W-1:0] result_q, result_d;
  logic           err_q, err_d;

  logic [W-1:0]   a_sel;
  logic           accept;
  logic           div_zero;
  logic           div_load;
  logic [W-1:0]   div_quo;
  logic [W-1:0]   div_rem;
  logic           div_valid;
  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;
  logic [2*W-1:0] alu_res;

`ifdef CALC_ACCUM_EN
  assign a_sel = bus.acc_sel ? result_q[W-1:0] : bus.a;
`else
  assign a_sel = bus.a;
`endif

  assign accept   = (state_q == ST_IDLE) && bus.start;
  assign div_zero = (bus.b == '0);
  assign div_load = accept && (bus.op == OP_DIV) && !div_zero;

  calc_div_iter #(.W(W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load),
    .dividend  (a_sel),
    .divisor   (bus.b),
    .quotient  (div_quo),
    .remainder (div_rem),
    .valid     (div_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.op != OP_DIV) begin
            state_d = ST_EXEC;
          end else if (div_zero) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DIV;
          end
        end
      end
      ST_EXEC: state_d = ST_DONE;
      ST_DIV:  if (div_valid) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q != ST_IDLE);
    bus.done = (state_q == ST_DONE);
  end

  assign a_ext = {{W{1'b0}}, a_q};
  assign b_ext = {{W{1'b0}}, b_q};

  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_MUL:  alu_res = a_ext * b_ext;
      default: alu_res = '0;
    endcase
  end

  // Result/err change only on the transition into DONE, so they hold between completions.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    err_d    = err_q;
    if (accept) begin
      a_d  = a_sel;
      b_d  = bus.b;
      op_d = bus.op;
      if ((bus.op == OP_DIV) && div_zero) begin
        result_d = DIV0_RESULT[2*W-1:0];
        err_d    = 1'b1;
      end
    end else if (state_q == ST_EXEC) begin
      result_d = alu_res;
      err_d    = 1'b0;
    end else if ((state_q == ST_DIV) && div_valid) begin
      result_d = {div_rem, div_quo};
      err_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign bus.result = result_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Self-checking bench for calc_sequencer: schedule-based reference model, directed and random stimulus.
module tb_calc_sequencer;

  localparam int W = 4;

  logic clk;
  logic rst;

  calc_sequencer_if #(.W(W)) bus ();

  calc_sequencer #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  // Reference model: outputs for the cycle following each rising edge.
  int         e         = 0;
  int         done_edge = 0;
  bit         active    = 0;
  logic       m_busy    = 0;
  logic       m_done    = 0;
  logic [7:0] m_res     = 0;
  logic       m_err     = 0;
  logic [7:0] pend_res  = 0;
  logic       pend_err  = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, got, exp, e);
    end
  endtask

  task automatic model_step();
    int         av;
    int         bv;
    int         lat;
    logic [7:0] r;
    logic       er;
    e++;
    if (rst) begin
      m_busy = 0; m_done = 0; m_res = 0; m_err = 0; active = 0;
      return;
    end
    m_done = 0;
    if (active) begin
      m_busy = 1;
      if (e == done_edge) begin
        m_done = 1; m_res = pend_res; m_err = pend_err; active = 0;
      end
    end else if (!m_busy && bus.start) begin
      av = int'(bus.a);
`ifdef CALC_ACCUM_EN
      if (bus.acc_sel) av = int'(m_res[3:0]);
`endif
      bv  = int'(bus.b);
      er  = 0;
      lat = 2;
      case (bus.op)
        2'd0:    r = 8'(av + bv);
        2'd1:    r = 8'(av - bv);
        2'd2:    r = 8'(av * bv);
        default: begin
          if (bv == 0) begin
            r = 8'hFF; er = 1; lat = 1;
          end else begin
            r = {4'(av % bv), 4'(av / bv)}; lat = W + 2;
          end
        end
      endcase
      m_busy = 1;
      if (lat == 1) begin
        m_done = 1; m_res = r; m_err = er;
      end else begin
        active = 1; done_edge = e + lat - 1; pend_res = r; pend_err = er;
      end
    end else begin
      m_busy = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("busy",   32'(bus.busy),   32'(m_busy));
        chk("done",   32'(bus.done),   32'(m_done));
        chk("result", 32'(bus.result), 32'(m_res));
        chk("err",    32'(bus.err),    32'(m_err));
      end
    end
  end

  task automatic do_op(input string nm, input logic [1:0] o, input logic [3:0] aa,
                       input logic [3:0] bb, input logic acc, input logic [7:0] er,
                       input logic ee, input int el);
    int k;
    bit seen;
    bus.start = 1; bus.op = o; bus.a = aa; bus.b = bb;
`ifdef CALC_ACCUM_EN
    bus.acc_sel = acc;
`endif
    tick();
    bus.start = 0; bus.op = 2'($urandom); bus.a = 4'($urandom); bus.b = 4'($urandom);
`ifdef CALC_ACCUM_EN
    bus.acc_sel = 1'($urandom);
`endif
    chk({nm, "_busy1"}, 32'(bus.busy), 1);
    k = 1; seen = 0;
    while (!seen && k <= 20) begin
      if (bus.done) seen = 1;
      else begin tick(); k++; end
    end
    chk({nm, "_seen_done"}, 32'(seen), 1);
    chk({nm, "_latency"}, 32'(k), 32'(el));
    chk({nm, "_result"}, 32'(bus.result), 32'(er));
    chk({nm, "_err"}, 32'(bus.err), 32'(ee));
    chk({nm, "_model"}, 32'(m_res), 32'(er));
    tick();
  endtask

  initial begin
    int n_done;
    rst = 1; bus.start = 0; bus.op = 0; bus.a = 0; bus.b = 0;
`ifdef CALC_ACCUM_EN
    bus.acc_sel = 0;
`endif
    tick();
    chk_en = 1;
    tick();
    chk("rst_busy",   32'(bus.busy),   0);
    chk("rst_done",   32'(bus.done),   0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_err",    32'(bus.err),    0);
    rst = 0;
    tick();

    do_op("add",     2'd0,  9,  7, 0, 8'h10, 0, 2);
    do_op("sub",     2'd1,  3,  5, 0, 8'hFE, 0, 2);
    do_op("mul",     2'd2, 15, 15, 0, 8'hE1, 0, 2);
    do_op("addmax",  2'd0, 15, 15, 0, 8'h1E, 0, 2);
    do_op("div",     2'd3, 13,  4, 0, 8'h13, 0, 6);
    do_op("div0",    2'd3,  7,  0, 0, 8'hFF, 1, 1);
    do_op("clr_err", 2'd0,  1,  2, 0, 8'h03, 0, 2);
    do_op("div_by1", 2'd3, 15,  1, 0, 8'h0F, 0, 6);
    do_op("div_sm",  2'd3,  3,  7, 0, 8'h30, 0, 6);

    // Extra starts during DIV and DONE must be dropped.
    bus.start = 1; bus.op = 2'd3; bus.a = 13; bus.b = 4;
    tick();
    bus.start = 1; bus.op = 2'd0; bus.a = 1; bus.b = 1;
    tick();
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) begin
        n_done++; bus.start = 1; bus.op = 2'd0;
      end else begin
        bus.start = 0;
      end
      tick();
    end
    bus.start = 0;
    chk("dbl_start_ndone",  32'(n_done), 1);
    chk("dbl_start_result", 32'(bus.result), 32'h13);

    // Reset while dividing.
    bus.start = 1; bus.op = 2'd3; bus.a = 14; bus.b = 3;
    tick();
    bus.start = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("rstdiv_busy",   32'(bus.busy),   0);
    chk("rstdiv_done",   32'(bus.done),   0);
    chk("rstdiv_result", 32'(bus.result), 0);
    chk("rstdiv_err",    32'(bus.err),    0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.done) n_done++;
      tick();
    end
    chk("rstdiv_nodone", 32'(n_done), 0);

`ifdef CALC_ACCUM_EN
    do_op("acc_rst", 2'd0, 9, 6, 1, 8'h06, 0, 2);
    do_op("acc_add", 2'd0, 2, 3, 0, 8'h05, 0, 2);
    do_op("acc_mul", 2'd2, 9, 4, 1, 8'h14, 0, 2);
`endif

    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 79) == 0);
      bus.start = ($urandom_range(0, 2) == 0);
      bus.op    = 2'($urandom);
      bus.a     = 4'($urandom);
      bus.b     = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
`ifdef CALC_ACCUM_EN
      bus.acc_sel = 1'($urandom);
`endif
      tick();
    end
    rst = 0; bus.start = 0;
    for (int i = 0; i < 10; i++) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
